// File: rtl/c3aibadapt_sr_pkg.sv
// Shared types for the serial/parallel shift chain: FSM states, control
// strobes from the sequencer to the datapath, and the bit counter width.
package c3aibadapt_sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sr_state_e;

    // Datapath strobes, valid only in the cycle they are asserted.
    typedef struct packed {
        logic load_en;   // chain <= par_in
        logic shift_en;  // chain shifts one position
        logic cap_en;    // par_out <= post-shift chain (last shift)
    } sr_ctl_t;

    // Counter must hold WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/c3aibadapt_sr_chain_ctrl.sv
// Sequencer for the shift chain: IDLE/SHIFT/DONE FSM plus the count of
// shifts still owed in the current sequence.
module c3aibadapt_sr_chain_ctrl
    import c3aibadapt_sr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic             shift_req,
    input  logic             abort,
    output sr_ctl_t          ctl,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    sr_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // State and counter registers; reset wins over every request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    // Next state: load beats shift in IDLE, abort cuts SHIFT short.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        case (state)
            ST_IDLE: begin
                if (!load_req && shift_req) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = CNT_W'(WIDTH);
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    // Saturate so the counter can never wrap.
                    cnt_nxt = (bit_cnt != '0) ? bit_cnt - CNT_W'(1) : '0;
                    if (bit_cnt <= CNT_W'(1))
                        state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: datapath strobes and status flags.
    always_comb begin
        ctl.load_en  = (state == ST_IDLE) && load_req;
        ctl.shift_en = (state == ST_SHIFT) && !abort;
        ctl.cap_en   = ctl.shift_en && (bit_cnt == CNT_W'(1));
        busy         = (state != ST_IDLE);
        done         = (state == ST_DONE);
    end

endmodule

// File: rtl/c3aibadapt_sr_chain.sv
// Serial/parallel shift chain: parallel load, WIDTH-bit shift sequence
// with abort, and a par_out shadow captured when a sequence completes.
module c3aibadapt_sr_chain
    import c3aibadapt_sr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_req,
    input  logic [WIDTH-1:0]          par_in,
    input  logic                      shift_req,
    input  logic                      abort,
    input  logic                      ser_in,
    output logic                      ser_out,
    output logic [WIDTH-1:0]          par_out,
    output logic                      busy,
    output logic                      done,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);

    sr_ctl_t          ctl;
    logic [WIDTH-1:0] chain;
    logic [WIDTH-1:0] chain_shf;

    c3aibadapt_sr_chain_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .shift_req (shift_req),
        .abort     (abort),
        .ctl       (ctl),
        .busy      (busy),
        .done      (done),
        .bit_cnt   (bit_cnt)
    );

    // Shift direction is fixed at elaboration; ser_in enters opposite ser_out.
    if (MSB_FIRST) begin : g_msb
        assign chain_shf = {chain[WIDTH-2:0], ser_in};
        assign ser_out   = chain[WIDTH-1];
    end else begin : g_lsb
        assign chain_shf = {ser_in, chain[WIDTH-1:1]};
        assign ser_out   = chain[0];
    end

    // Chain register: load or shift as strobed; holds otherwise (incl. abort).
    always_ff @(posedge clk) begin
        if (rst)
            chain <= RESET_VAL;
        else if (ctl.load_en)
            chain <= par_in;
        else if (ctl.shift_en)
            chain <= chain_shf;
    end

    // Shadow copy takes the post-shift value on the final shift only.
    always_ff @(posedge clk) begin
        if (rst)
            par_out <= RESET_VAL;
        else if (ctl.cap_en)
            par_out <= chain_shf;
    end

endmodule

// File: tb/tb_c3aibadapt_sr_chain.sv
// Bench for c3aibadapt_sr_chain: two 8-bit instances (MSB-first and
// LSB-first) on shared inputs, a vector table, directed corner sequences
// and a randomized run checked against a cycle-level reference model.
module tb_c3aibadapt_sr_chain;

    logic       clk = 1'b0;
    logic       rst, load_req, shift_req, abort, ser_in;
    logic [7:0] par_in;

    logic       so0, so1, busy0, busy1, done0, done1;
    logic [7:0] po0, po1;
    logic [3:0] cnt0, cnt1;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: mode 0 idle, 1 shifting, 2 done.
    int         m_mode, m_rem;
    logic [7:0] m_c0, m_c1, m_p0, m_p1;

    typedef struct {
        logic       ld, sh, si;
        logic [7:0] pi;
        logic       e_busy, e_done;
        logic [3:0] e_cnt;
        logic [7:0] e_par;
        logic       e_so;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    c3aibadapt_sr_chain #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load_req(load_req), .par_in(par_in),
        .shift_req(shift_req), .abort(abort), .ser_in(ser_in),
        .ser_out(so0), .par_out(po0), .busy(busy0), .done(done0), .bit_cnt(cnt0)
    );

    c3aibadapt_sr_chain #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load_req(load_req), .par_in(par_in),
        .shift_req(shift_req), .abort(abort), .ser_in(ser_in),
        .ser_out(so1), .par_out(po1), .busy(busy1), .done(done1), .bit_cnt(cnt1)
    );

    function automatic vec_t mk(input logic ld, sh, si, input logic [7:0] pi,
                                input logic eb, ed, input logic [3:0] ec,
                                input logic [7:0] ep, input logic eso);
        vec_t v;
        v.ld = ld; v.sh = sh; v.si = si; v.pi = pi;
        v.e_busy = eb; v.e_done = ed; v.e_cnt = ec; v.e_par = ep; v.e_so = eso;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of the reference model, applied to the inputs about to be sampled.
    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_rem = 0;
            m_c0 = 8'h00; m_c1 = 8'h00; m_p0 = 8'h00; m_p1 = 8'h00;
        end else if (m_mode == 0) begin
            if (load_req) begin
                m_c0 = par_in; m_c1 = par_in;
            end else if (shift_req) begin
                m_mode = 1; m_rem = 8;
            end
        end else if (m_mode == 1) begin
            if (abort) begin
                m_mode = 0; m_rem = 0;
            end else begin
                m_c0 = 8'((int'(m_c0) * 2) + int'(ser_in));
                m_c1 = 8'((int'(m_c1) / 2) + int'(ser_in) * 128);
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_mode = 2; m_p0 = m_c0; m_p1 = m_c1;
                end
            end
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("m_busy0", busy0, m_mode != 0);
        chk("m_busy1", busy1, m_mode != 0);
        chk("m_done0", done0, m_mode == 2);
        chk("m_done1", done1, m_mode == 2);
        chk("m_cnt0",  cnt0,  m_rem);
        chk("m_cnt1",  cnt1,  m_rem);
        chk("m_so0",   so0,   m_c0[7]);
        chk("m_so1",   so1,   m_c1[0]);
        chk("m_par0",  po0,   m_p0);
        chk("m_par1",  po1,   m_p1);
    endtask

    task automatic idle_in();
        rst = 1'b0; load_req = 1'b0; shift_req = 1'b0; abort = 1'b0; ser_in = 1'b0;
        par_in = 8'h00;
    endtask

    initial begin
        logic [7:0] stream;
        int         dcount;
        stream = 8'b0011_1100;  // applied MSB of this byte first: 0,0,1,1,1,1,0,0

        // Load A5 then a full MSB-first shift sequence.
        tbl[0]  = mk(1, 0, 0, 8'hA5, 0, 0, 4'd0, 8'h00, 1);
        tbl[1]  = mk(0, 1, 0, 8'h00, 1, 0, 4'd8, 8'h00, 1);
        tbl[2]  = mk(0, 0, 0, 8'h00, 1, 0, 4'd7, 8'h00, 0);
        tbl[3]  = mk(0, 0, 0, 8'h00, 1, 0, 4'd6, 8'h00, 1);
        tbl[4]  = mk(0, 0, 1, 8'h00, 1, 0, 4'd5, 8'h00, 0);
        tbl[5]  = mk(0, 0, 1, 8'h00, 1, 0, 4'd4, 8'h00, 0);
        tbl[6]  = mk(0, 0, 1, 8'h00, 1, 0, 4'd3, 8'h00, 1);
        tbl[7]  = mk(0, 0, 1, 8'h00, 1, 0, 4'd2, 8'h00, 0);
        tbl[8]  = mk(0, 0, 0, 8'h00, 1, 0, 4'd1, 8'h00, 1);
        tbl[9]  = mk(0, 0, 0, 8'h00, 1, 1, 4'd0, 8'h3C, 0);
        tbl[10] = mk(0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h3C, 0);

        // Reset held two cycles.
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_par", po0, 8'h00);
        chk("rst_so",  so0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_cnt", cnt0, 4'd0);

        // Vector table, first row in the very first cycle out of reset.
        for (int i = 0; i < 11; i++) begin
            load_req = tbl[i].ld; shift_req = tbl[i].sh; ser_in = tbl[i].si;
            par_in = tbl[i].pi;
            tick();
            chk($sformatf("tbl%0d_busy", i), busy0, tbl[i].e_busy);
            chk($sformatf("tbl%0d_done", i), done0, tbl[i].e_done);
            chk($sformatf("tbl%0d_cnt", i),  cnt0,  tbl[i].e_cnt);
            chk($sformatf("tbl%0d_par", i),  po0,   tbl[i].e_par);
            chk($sformatf("tbl%0d_so", i),   so0,   tbl[i].e_so);
        end
        chk("stream_sanity_model", m_c0, stream);

        // Load and shift together: load wins, shift dropped.
        idle_in();
        load_req = 1'b1; shift_req = 1'b1; par_in = 8'h5A;
        tick();
        idle_in();
        chk("ldsh_busy", busy0, 1'b0);
        chk("ldsh_so0", so0, 1'b0);
        tick();
        chk("ldsh_busy2", busy0, 1'b0);
        chk("ldsh_done", done0, 1'b0);
        check_model();

        // Abort after four shifts.
        shift_req = 1'b1;
        tick();
        idle_in();
        ser_in = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("ab_cnt4", cnt0, 4'd4);
        abort = 1'b1;
        tick();
        idle_in();
        chk("ab_busy", busy0, 1'b0);
        chk("ab_cnt",  cnt0, 4'd0);
        chk("ab_done", done0, 1'b0);
        chk("ab_par",  po0, 8'h3C);
        check_model();   // chain holds 5A<<4 | 1111 = AF
        chk("ab_so0", so0, 1'b1);
        tick();
        chk("ab_done2", done0, 1'b0);

        // Reset mid-sequence at bit_cnt=3.
        shift_req = 1'b1;
        tick();
        idle_in();
        for (int k = 0; k < 5; k++) tick();
        chk("rs_cnt3", cnt0, 4'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_busy", busy0, 1'b0);
        chk("rs_cnt", cnt0, 4'd0);
        chk("rs_par", po0, 8'h00);
        chk("rs_so", so0, 1'b0);
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done0 || done1) dcount++;
        end
        chk("rs_no_done", dcount, 0);

        // LSB-first: load 01, shift in eight ones.
        load_req = 1'b1; par_in = 8'h01;
        tick();
        idle_in();
        shift_req = 1'b1;
        tick();
        idle_in();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lsb_so%0d", k), so1, (k == 0) ? 1'b1 : 1'b0);
            ser_in = 1'b1;
            tick();
        end
        idle_in();
        chk("lsb_done", done1, 1'b1);
        chk("lsb_par", po1, 8'hFF);
        check_model();
        tick();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            load_req  = ($urandom_range(0, 5) == 0);
            shift_req = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 24) == 0);
            ser_in    = 1'($urandom);
            par_in    = 8'($urandom);
            tick();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/c3aibadapt_sr_chain.md
C3AIBADAPT_SR_CHAIN -- requirements
Module: c3aibadapt_sr_chain

Interface
REQ-001 Parameter WIDTH, default 16, chain length in bits; legal range 2..256.
REQ-002 Parameter RESET_VAL, default {WIDTH{1'b0}}, reset value of the chain and of par_out.
REQ-003 Parameter MSB_FIRST, default 1; 1 = shift toward MSB, ser_out = bit WIDTH-1; 0 = shift toward LSB, ser_out = bit 0.
REQ-004 clk  input  1  single clock; all state updates on the posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_req  input  1  parallel-load request, sampled in IDLE only.
REQ-007 par_in  input  WIDTH  parallel load data.
REQ-008 shift_req  input  1  start a WIDTH-bit shift sequence, sampled in IDLE only.
REQ-009 abort  input  1  terminate an active shift sequence.
REQ-010 ser_in  input  1  serial data entering the chain.
REQ-011 ser_out  output  1  serial data leaving the chain, taken directly from the chain register (no added logic depth).
REQ-012 par_out  output  WIDTH  shadow copy of the chain, updated only on sequence completion.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 bit_cnt  output  clog2(WIDTH+1)  number of shifts remaining in the current sequence.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 IDLE, load_req=1: at the edge, the chain SHALL take par_in; state stays IDLE; busy stays 0.
REQ-018 IDLE, shift_req=1 and load_req=0: at edge T, state SHALL go to SHIFT and bit_cnt SHALL be set to WIDTH.
REQ-019 IDLE, load_req=1 and shift_req=1 in the same cycle: load SHALL win; shift_req SHALL be dropped and must be reissued.
REQ-020 SHIFT, each edge: the chain SHALL shift one position, ser_in SHALL enter at the end opposite ser_out, and bit_cnt SHALL decrement by 1.
REQ-021 Shifts SHALL occur at edges T+1 through T+WIDTH.
REQ-022 At edge T+WIDTH (bit_cnt 1->0):
- state SHALL go to DONE;
- par_out SHALL take the post-shift chain value in the same edge.
REQ-023 done SHALL be high for exactly the one DONE cycle; the next edge SHALL return the FSM to IDLE.
REQ-024 load_req and shift_req SHALL be ignored in SHIFT and DONE.
REQ-025 abort in SHIFT: at the next edge the FSM SHALL go to IDLE and bit_cnt to 0; no shift on that edge; the chain holds its partial content; par_out unchanged; no done.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 bit_cnt SHALL never underflow, and SHALL read 0 in IDLE and DONE.

Reset
REQ-028 While rst=1 at an edge, regardless of state or other inputs:
- chain and par_out SHALL become RESET_VAL;
- FSM SHALL become IDLE; bit_cnt 0; done 0; busy 0.
REQ-029 rst SHALL override abort, load_req and shift_req.
REQ-030 Reset during SHIFT SHALL discard the sequence; no done SHALL follow.
REQ-031 The first request SHALL be accepted in the first cycle with rst=0.

Structure
REQ-032 State encodings and the bit_cnt width function SHALL reside in shared package c3aibadapt_sr_pkg.
REQ-033 The FSM and bit counter SHALL be a sub-module c3aibadapt_sr_chain_ctrl.
REQ-034 The chain datapath and par_out SHALL remain in the top module.

Verification
REQ-035 WIDTH=8, rst held 2 cycles -> par_out=8'h00, ser_out=0, busy=0, done=0, bit_cnt=0.
REQ-036 WIDTH=8, MSB_FIRST=1; load 8'hA5, then shift_req with ser_in stream 0,0,1,1,1,1,0,0 ->
- ser_out 1,0,1,0,0,1,0,1 over shift cycles 1..8;
- done high only in cycle T+9 (the DONE cycle entered at edge T+8);
- par_out=8'h3C.
REQ-037 load_req=1 and shift_req=1 together with par_in=8'h5A -> chain=8'h5A, busy stays 0, no done.
REQ-038 abort after 4 shifts of an 8-bit sequence -> IDLE at next edge, bit_cnt=0, no done, par_out holds its previous value.
REQ-039 rst asserted at bit_cnt=3 -> all outputs at reset values next cycle; no done within the following 10 cycles.
REQ-040 MSB_FIRST=0, load 8'h01, shift 8 bits of ser_in=1 -> ser_out 1,0,0,0,0,0,0,0; par_out=8'hFF.
